conv_seq_ctrl: RTL
==================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter GRP_W, default 10: width of the group counter; one group = 16 MAC lanes of one conv_unit pass.
REQ-002 Parameter PIX_W, default 16: width of the output-pixel counter.
REQ-003 Parameter ADDR_W, default 16: width of the weight and feature-map buffer read addresses.
REQ-004 Port clk, input, 1: clock.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: single-cycle pulse that begins a layer; ignored unless the block is in IDLE.
REQ-007 Port cfg_num_grp, input, GRP_W: groups per output pixel; 0 is treated as 1.
REQ-008 Port cfg_num_pix, input, PIX_W: output pixels per layer; 0 completes with no output.
REQ-009 Port cfg_bias_en, input, 1: the layer uses bias.
REQ-010 Ports wt_rd_en / fm_rd_en, output, 1: read strobes to the weight and feature-map buffers; read data returns exactly 1 cycle later.
REQ-011 Ports wt_rd_addr / fm_rd_addr, output, ADDR_W: wt_rd_addr = group index; fm_rd_addr = pixel*cfg_num_grp + group, truncated to ADDR_W.
REQ-012 Ports cu_enable, cu_fm_valid, cu_wt_valid, cu_bias_en, output, 1 each: drive the conv unit's enable, feature-map update, weight update and bias select.
REQ-013 Ports cu_dout (input, 32, signed) and cu_dout_valid (input, 1): the conv unit's registered result.
REQ-014 Ports out_data (output, 32, signed), out_valid (output, 1), out_ready (input, 1): per-pixel result with a valid/ready handshake.
REQ-015 Ports busy and done, output, 1 each: busy is high outside IDLE; done is a 1-cycle pulse when the layer completes.

Function
REQ-016 The FSM shall have states IDLE, ISSUE, DRAIN, OUT and FIN.
REQ-017 IDLE->ISSUE on start with cfg_num_pix!=0. IDLE->FIN on start with cfg_num_pix==0. The block latches all cfg_* inputs on start.
REQ-018 ISSUE: the block asserts wt_rd_en and fm_rd_en every cycle, one group per cycle; it moves to DRAIN in the cycle after issuing the last group.
REQ-019 Cycle t+1 after a read at cycle t: cu_enable=cu_fm_valid=cu_wt_valid=1; cu_bias_en=cfg_bias_en only for group 0, otherwise 0.
REQ-020 On each cu_dout_valid, the accumulator loads cu_dout for group 0 and adds cu_dout for later groups.
REQ-021 DRAIN->OUT when the last group's cu_dout_valid has been accumulated, which occurs exactly 2 cycles after its read.
REQ-022 OUT: out_valid=1 and out_data=accumulator, both held stable until out_ready is sampled high.
REQ-023 On acceptance, OUT->ISSUE for the next pixel with the group counter reset to 0. After the last pixel, OUT->FIN instead.
REQ-024 FIN pulses done for 1 cycle, then returns to IDLE.
REQ-025 Latency: the first out_valid for a pixel occurs cfg_num_grp+2 cycles after entering ISSUE.
REQ-026 start while busy shall have no effect. A cu_dout_valid that arrives unexpectedly in IDLE shall be ignored.
REQ-027 The group and pixel counters shall never wrap inside a layer; the last-item compare is (count == cfg-1).

Reset
REQ-028 Reset returns the FSM to IDLE and clears all counters and the accumulator.
REQ-029 Reset drives every output to 0: rd_en, addresses, cu_*, out_data, out_valid, busy, done.
REQ-030 Reset mid-layer abandons in-flight reads. The first post-reset start begins a clean layer.

Configuration
REQ-031 Macro CONV_SEQ_ACC_SAT_EN defined: accumulation saturates to [-2^31, 2^31-1].
REQ-032 Macro CONV_SEQ_ACC_SAT_EN undefined: accumulation wraps modulo 2^32.

Verification
REQ-033 cfg_num_grp=3, cfg_num_pix=2, bias on, cu_dout returns 100,5,7 per pixel, out_ready=1 -> out_data=112 twice; cu_bias_en high only on group 0; done 1 cycle after the second acceptance.
REQ-034 out_ready held low 10 cycles in OUT -> out_valid and out_data stable, no rd_en asserted, handshake completes on the first cycle out_ready=1.
REQ-035 cfg_num_pix=0, start -> no rd_en, done pulses, back in IDLE within 2 cycles.
REQ-036 cfg_num_grp=2, cu_dout 0x7FFFFFF0 then 0x20 -> 0x7FFFFFFF with CONV_SEQ_ACC_SAT_EN defined, 0x80000010 without it.
REQ-037 rst_n pulsed low mid-ISSUE of pixel 1 -> all outputs 0 asynchronously; a new start with cfg_num_grp=1, cfg_num_pix=1 yields a single correct result.
REQ-038 start asserted while busy -> ignored, cfg unchanged, the layer finishes with the original pixel count.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences one conv layer. Issues weight/feature-map reads one
// group per cycle, steers the conv unit, accumulates its per-group results
// and hands each pixel's sum out over a valid/ready handshake.
// Optional build macro: CONV_SEQ_ACC_SAT_EN (saturating accumulation; wraps
// modulo 2^32 when undefined).
module conv_seq_ctrl #(
    parameter int unsigned GRP_W  = 10,
    parameter int unsigned PIX_W  = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [GRP_W-1:0]         cfg_num_grp,
    input  logic [PIX_W-1:0]         cfg_num_pix,
    input  logic                     cfg_bias_en,
    output logic                     wt_rd_en,
    output logic                     fm_rd_en,
    output logic [ADDR_W-1:0]        wt_rd_addr,
    output logic [ADDR_W-1:0]        fm_rd_addr,
    output logic                     cu_enable,
    output logic                     cu_fm_valid,
    output logic                     cu_wt_valid,
    output logic                     cu_bias_en,
    input  logic signed [31:0]       cu_dout,
    input  logic                     cu_dout_valid,
    output logic signed [31:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [GRP_W-1:0]         grp_q, grp_d, acc_cnt_q, acc_cnt_d, ng_q, ng_d, grp_inc;
    logic [PIX_W-1:0]         pix_q, pix_d, np_q, np_d;
    logic [ADDR_W-1:0]        base_q, base_d, base_inc;
    logic                     bias_q, bias_d;
    logic signed [DATA_W-1:0] acc_q, acc_d, acc_sum;
    logic                     acc_last;
    logic                     rd_en_d, cu_en_d, cu_bias_d, out_valid_d, busy_d, done_d;
    logic [ADDR_W-1:0]        wt_addr_d, fm_addr_d;
    logic signed [DATA_W-1:0] out_data_d;

    // Accumulator adder: saturating or wrapping depending on the build
    function automatic logic signed [DATA_W-1:0] acc_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
`ifdef CONV_SEQ_ACC_SAT_EN
        logic [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1])
            return sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return sum[DATA_W-1:0];
`else
        return a + b;
`endif
    endfunction

    // State, counters, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grp_q       <= '0;
            pix_q       <= '0;
            acc_cnt_q   <= '0;
            base_q      <= '0;
            ng_q        <= '0;
            np_q        <= '0;
            bias_q      <= 1'b0;
            acc_q       <= '0;
            wt_rd_en    <= 1'b0;
            fm_rd_en    <= 1'b0;
            wt_rd_addr  <= '0;
            fm_rd_addr  <= '0;
            cu_enable   <= 1'b0;
            cu_fm_valid <= 1'b0;
            cu_wt_valid <= 1'b0;
            cu_bias_en  <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            pix_q       <= pix_d;
            acc_cnt_q   <= acc_cnt_d;
            base_q      <= base_d;
            ng_q        <= ng_d;
            np_q        <= np_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            wt_rd_en    <= rd_en_d;
            fm_rd_en    <= rd_en_d;
            wt_rd_addr  <= wt_addr_d;
            fm_rd_addr  <= fm_addr_d;
            cu_enable   <= cu_en_d;
            cu_fm_valid <= cu_en_d;
            cu_wt_valid <= cu_en_d;
            cu_bias_en  <= cu_bias_d;
            out_data    <= out_data_d;
            out_valid   <= out_valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        pix_d       = pix_q;
        acc_cnt_d   = acc_cnt_q;
        base_d      = base_q;
        ng_d        = ng_q;
        np_d        = np_q;
        bias_d      = bias_q;
        acc_d       = acc_q;
        rd_en_d     = 1'b0;
        wt_addr_d   = '0;
        fm_addr_d   = '0;
        out_valid_d = 1'b0;
        out_data_d  = out_data;

        grp_inc  = grp_q + GRP_W'(1);
        base_inc = base_q + ADDR_W'(ng_q);
        acc_last = (acc_cnt_q == ng_q - GRP_W'(1));
        acc_sum  = (acc_cnt_q == '0) ? cu_dout : acc_add(acc_q, cu_dout);

        // Results are only expected while a pixel is in flight
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && cu_dout_valid) begin
            acc_d     = acc_sum;
            acc_cnt_d = acc_cnt_q + GRP_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ng_d      = (cfg_num_grp == '0) ? GRP_W'(1) : cfg_num_grp;
                    np_d      = cfg_num_pix;
                    bias_d    = cfg_bias_en;
                    grp_d     = '0;
                    pix_d     = '0;
                    base_d    = '0;
                    acc_cnt_d = '0;
                    if (cfg_num_pix == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (grp_q == ng_q - GRP_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    grp_d     = grp_inc;
                    rd_en_d   = 1'b1;
                    wt_addr_d = ADDR_W'(grp_inc);
                    fm_addr_d = base_q + ADDR_W'(grp_inc);
                end
            end
            S_DRAIN: begin
                if (cu_dout_valid && acc_last) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_sum;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (pix_q == np_q - PIX_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d   = S_ISSUE;
                        pix_d     = pix_q + PIX_W'(1);
                        base_d    = base_inc;
                        grp_d     = '0;
                        acc_cnt_d = '0;
                        rd_en_d   = 1'b1;
                        fm_addr_d = base_inc;
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Conv unit strobes trail the read by one cycle; bias only on group 0
        cu_en_d   = wt_rd_en;
        cu_bias_d = wt_rd_en && (grp_q == '0) && bias_q;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
    end

endmodule
